// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch mode controller.
package stopwatch_pkg;

    localparam int JSTK_W = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_FWD = 3'd1,
        RUN_BWD = 3'd2,
        PAUSED  = 3'd3,
        ADJUST  = 3'd4
    } sw_state_t;

    typedef enum logic [1:0] {
        ZONE_CENTER = 2'd0,
        ZONE_FWD    = 2'd1,
        ZONE_BWD    = 2'd2
    } zone_t;

    function automatic zone_t zone_decode(input logic [JSTK_W-1:0] x,
                                          input logic [JSTK_W-1:0] hi,
                                          input logic [JSTK_W-1:0] lo);
        if (x >= hi) return ZONE_FWD;
        if (x <= lo) return ZONE_BWD;
        return ZONE_CENTER;
    endfunction

    function automatic logic is_run(input sw_state_t s);
        return (s == RUN_FWD) || (s == RUN_BWD);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF sync, stable-sample down-counter, one-cycle pulse on accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_m;
    logic          sync_s;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // cnt reaching zero means DEBOUNCE_CYCLES consecutive samples disagreed with the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_m  <= 1'b0;
            sync_s  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= RELOAD;
        end else begin
            sync_m  <= btn_raw;
            sync_s  <= sync_m;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync_s == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync_s;
                cnt   <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode/sequencing controller: input conditioning, joystick zones, run/adjust FSM and
// the prescaler that issues single-cycle counter step enables.
//
//   state   | meaning
//   IDLE    | after reset or clear, counter stopped
//   RUN_FWD | counting up at run rate
//   RUN_BWD | counting down at run rate
//   PAUSED  | stopped, prescaler fraction held
//   ADJUST  | manual set, stepping selected field at adjust rate
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int RUN_DIV         = 100_000_000,
    parameter int ADJ_DIV         = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int JSTK_HI         = 900,
    parameter int JSTK_LO         = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_pause,
    input  logic              btn_clear,
    input  logic              sw_adj,
    input  logic              sw_sel,
    input  logic [JSTK_W-1:0] jstk_x,
    input  logic              jstk_valid,
    output logic              tick_en,
    output logic              step_dir,
    output logic              step_field,
    output logic              cnt_clear,
    output logic              running,
    output logic [2:0]        state
);

    localparam int MAX_DIV = (RUN_DIV > ADJ_DIV) ? RUN_DIV : ADJ_DIV;
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [PW-1:0]     RUN_TC = PW'(RUN_DIV - 1);
    localparam logic [PW-1:0]     ADJ_TC = PW'(ADJ_DIV - 1);
    localparam logic [JSTK_W-1:0] HI     = JSTK_W'(JSTK_HI);
    localparam logic [JSTK_W-1:0] LO     = JSTK_W'(JSTK_LO);

    sw_state_t     state_q, state_n;
    zone_t         zone_q, zone_n;
    logic          saved_dir, saved_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick_n, dir_n, field_n, clear_n;
    logic          adj_m, adj_s, sel_m, sel_s;
    logic          pause_p, clear_p;
    logic          fwd_entry, bwd_entry;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_pause),
        .press   (pause_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .press   (clear_p)
    );

    // Commands fire only when a sample moves the stick into a new deflected zone
    always_comb begin
        zone_n = zone_q;
        if (jstk_valid) zone_n = zone_decode(jstk_x, HI, LO);
    end

    assign fwd_entry = jstk_valid && (zone_n == ZONE_FWD) && (zone_q != ZONE_FWD);
    assign bwd_entry = jstk_valid && (zone_n == ZONE_BWD) && (zone_q != ZONE_BWD);

    always_comb begin
        state_n = state_q;
        saved_n = saved_dir;
        presc_n = presc;
        tick_n  = 1'b0;
        dir_n   = step_dir;
        field_n = step_field;
        clear_n = 1'b0;
        if (clear_p) begin
            state_n = IDLE;
            saved_n = 1'b1;
            presc_n = '0;
            clear_n = 1'b1;
        end else if (state_q != ADJUST && adj_s) begin
            state_n = ADJUST;
            presc_n = '0;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    if (pause_p)        state_n = saved_dir ? RUN_FWD : RUN_BWD;
                    else if (fwd_entry) state_n = RUN_FWD;
                    else if (bwd_entry) state_n = RUN_BWD;
                end
                RUN_FWD: begin
                    if (pause_p) begin
                        state_n = PAUSED;
                        saved_n = 1'b1;
                    end else if (bwd_entry) begin
                        state_n = RUN_BWD;
                    end
                end
                RUN_BWD: begin
                    if (pause_p) begin
                        state_n = PAUSED;
                        saved_n = 1'b0;
                    end else if (fwd_entry) begin
                        state_n = RUN_FWD;
                    end
                end
                ADJUST: begin
                    if (!adj_s) begin
                        state_n = PAUSED;
                        presc_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
            // Prescaler only advances while staying in a counting mode, so a direction swap keeps phase
            if (state_q == ADJUST && state_n == ADJUST) begin
                if (presc == ADJ_TC) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    dir_n   = 1'b1;
                    field_n = sel_s;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end else if (is_run(state_q) && is_run(state_n)) begin
                if (presc == RUN_TC) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    dir_n   = (state_n == RUN_FWD);
                    field_n = 1'b1;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            zone_q     <= ZONE_CENTER;
            saved_dir  <= 1'b1;
            presc      <= '0;
            tick_en    <= 1'b0;
            step_dir   <= 1'b1;
            step_field <= 1'b1;
            cnt_clear  <= 1'b0;
            adj_m      <= 1'b0;
            adj_s      <= 1'b0;
            sel_m      <= 1'b0;
            sel_s      <= 1'b0;
        end else begin
            state_q    <= state_n;
            zone_q     <= zone_n;
            saved_dir  <= saved_n;
            presc      <= presc_n;
            tick_en    <= tick_n;
            step_dir   <= dir_n;
            step_field <= field_n;
            cnt_clear  <= clear_n;
            adj_m      <= sw_adj;
            adj_s      <= adj_m;
            sel_m      <= sw_sel;
            sel_s      <= sel_m;
        end
    end

    assign running = is_run(state_q);
    assign state   = state_q;

endmodule
